// File: rtl/read_ddr_unpacker_if.sv
// read_ddr_unpacker_if: DDR read-data input and output beat stream of read_ddr_unpacker.
interface read_ddr_unpacker_if #(
    parameter int IN_WIDTH    = 256,
    parameter int OUT_WIDTH   = 32,
    parameter int DEPTH_WIDTH = 8
);
    logic [IN_WIDTH-1:0]    in_data;
    logic                   in_valid;
    logic                   in_full;
    logic [DEPTH_WIDTH:0]   water_level;
    logic                   almost_full;
    logic                   almost_empty;
    logic                   overflow;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_full, water_level, almost_full, almost_empty, overflow, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_full, water_level, almost_full, almost_empty, overflow, out_data, out_valid, out_last
    );
endinterface

// File: rtl/read_ddr_unpacker.sv
// read_ddr_unpacker: buffers IN_WIDTH DDR read words in a circular memory and
// unpacks each one, least-significant slice first, onto an OUT_WIDTH valid/ready stream.
module read_ddr_unpacker #(
    parameter int IN_WIDTH         = 256,
    parameter int OUT_WIDTH        = 32,
    parameter int DEPTH_WIDTH      = 8,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input logic clk,
    input logic rst,
    read_ddr_unpacker_if.slave bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;
    localparam logic [DEPTH_WIDTH:0] FULL_LVL = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AF_LVL = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] AE_LVL = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];
    localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

    logic [IN_WIDTH-1:0] mem [2**DEPTH_WIDTH];
    logic [IN_WIDTH-1:0] word;
    logic [DEPTH_WIDTH:0] wptr, rptr, level, level_n;
    logic [IW-1:0] idx;
    logic [0:0] state;
    logic full, overflow, almost_full, almost_empty;
    logic empty, push, hs, pop, at_last;

    assign empty   = wptr == rptr;
    assign push    = bus.in_valid && !full;
    assign at_last = idx == LAST;
    assign hs      = (state == S_HOLD) && bus.out_ready;
    // Last-beat handshake reloads the unpack register in the same edge, so no bubble.
    assign pop     = !empty && (state == S_EMPTY || (hs && at_last));
    assign level_n = level + (DEPTH_WIDTH+1)'(push) - (DEPTH_WIDTH+1)'(pop);

    always_ff @(posedge clk)
        if (push) mem[wptr[DEPTH_WIDTH-1:0]] <= bus.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            word         <= '0;
            idx          <= '0;
            state        <= S_EMPTY;
        end else begin
            wptr         <= wptr + (DEPTH_WIDTH+1)'(push);
            rptr         <= rptr + (DEPTH_WIDTH+1)'(pop);
            level        <= level_n;
            full         <= level_n == FULL_LVL;
            almost_full  <= level_n >= AF_LVL;
            almost_empty <= level_n <= AE_LVL;
            overflow     <= overflow | (bus.in_valid & full);
            if (pop) begin
                word  <= mem[rptr[DEPTH_WIDTH-1:0]];
                idx   <= '0;
                state <= S_HOLD;
            end else if (hs) begin
                idx   <= idx + IW'(1);
                state <= at_last ? S_EMPTY : S_HOLD;
            end
        end
    end

    assign bus.in_full      = full;
    assign bus.water_level  = level;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.overflow     = overflow;
    assign bus.out_valid    = state == S_HOLD;
    assign bus.out_data     = word[idx*OUT_WIDTH +: OUT_WIDTH];
    assign bus.out_last     = (state == S_HOLD) && at_last;
endmodule

// File: tb/tb_read_ddr_unpacker.sv
// tb_read_ddr_unpacker: randomized bench comparing read_ddr_unpacker against a
// count-and-queue reference model of the buffer and its beat stream.
module tb_read_ddr_unpacker;
    localparam int DEPTH = 256;

    logic clk, rst;
    read_ddr_unpacker_if #(.IN_WIDTH(256), .OUT_WIDTH(32), .DEPTH_WIDTH(8)) bus();
    read_ddr_unpacker dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass, n_chk;
    int stored, left, consumed, acc;
    bit held, ovf;
    logic [31:0] beats[$];

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] mk(int w);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = {w[15:0], j[15:0]};
        return r;
    endfunction

    function automatic logic [31:0] pat(int w, int j);
        return {w[15:0], j[15:0]};
    endfunction

    // One clock: check the presented beat, advance the model with the inputs seen at the edge.
    task automatic step();
        bit v, r, push, hs, pop;
        v = bus.in_valid;
        r = bus.out_ready;
        check("out_valid", bus.out_valid, held);
        if (held) begin
            check("out_data", bus.out_data, beats[0]);
            check("out_last", bus.out_last, left == 1);
        end
        push = v && stored < DEPTH;
        hs   = held && r;
        pop  = stored > 0 && (!held || (hs && left == 1));
        if (v && stored == DEPTH) ovf = 1;
        if (push) for (int j = 0; j < 8; j++) beats.push_back(bus.in_data[j*32 +: 32]);
        if (hs) begin
            void'(beats.pop_front());
            consumed++;
        end
        if (pop) begin
            held = 1;
            left = 8;
        end else if (hs) begin
            left--;
            if (left == 0) held = 0;
        end
        stored = stored + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        check("water_level", bus.water_level, stored);
        check("in_full", bus.in_full, stored == DEPTH);
        check("almost_full", bus.almost_full, stored >= 252);
        check("almost_empty", bus.almost_empty, stored <= 4);
        check("overflow", bus.overflow, ovf);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.in_valid = 0;
        bus.out_ready = 0;
        @(posedge clk);
        #1;
        rst = 0;
        stored = 0; left = 0; held = 0; ovf = 0; consumed = 0;
        beats.delete();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_level", bus.water_level, 0);
        check("rst_in_full", bus.in_full, 0);
        check("rst_almost_full", bus.almost_full, 0);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_overflow", bus.overflow, 0);
    endtask

    task automatic drain(int bound);
        bus.in_valid = 0;
        bus.out_ready = 1;
        for (int n = 0; n < bound && (held || stored > 0); n++) step();
        if (held || stored > 0) check("drain_timeout", 0, 1);
        check("drain_beats_left", beats.size(), 0);
        check("drain_idle_valid", bus.out_valid, 0);
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        bus.in_data = '0;
        do_reset();

        // Reset then idle
        for (int n = 0; n < 20; n++) begin
            bus.out_ready = $urandom_range(0, 1);
            step();
        end

        // Single word with slice i = i
        bus.out_ready = 1;
        bus.in_valid = 1;
        for (int j = 0; j < 8; j++) bus.in_data[j*32 +: 32] = j;
        step();
        bus.in_valid = 0;
        check("t2_latency_gap", bus.out_valid, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            check("t2_beat", bus.out_data, i);
            check("t2_last", bus.out_last, i == 7);
            step();
        end
        check("t2_done", bus.out_valid, 0);

        // Overfill with a stalled consumer, then drain across the pointer wrap
        do_reset();
        bus.in_valid = 1;
        for (int w = 0; w < 300; w++) begin
            bus.in_data = mk(w);
            step();
        end
        check("t3_level", bus.water_level, 256);
        check("t3_in_full", bus.in_full, 1);
        check("t3_overflow", bus.overflow, 1);
        check("t3_head", bus.out_data, pat(0, 0));
        drain(3000);

        // Random back-pressure with flow control on almost_full
        do_reset();
        acc = 0;
        for (int n = 0; n < 40000 && acc < 1500; n++) begin
            bus.in_valid = !bus.almost_full;
            for (int j = 0; j < 8; j++) bus.in_data[j*32 +: 32] = $urandom;
            bus.out_ready = $urandom_range(0, 1);
            if (bus.in_valid && stored < DEPTH) acc++;
            step();
        end
        if (acc < 1500) check("t4_timeout", acc, 1500);
        drain(5000);
        check("t4_overflow", bus.overflow, 0);

        // Push coinciding with last-beat pop at water_level 100
        do_reset();
        bus.in_valid = 1;
        for (int w = 0; w < 101; w++) begin
            bus.in_data = mk(w);
            step();
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        for (int n = 0; n < 7; n++) step();
        check("t5_at_last", bus.out_last, 1);
        bus.in_valid = 1;
        bus.in_data = mk(101);
        step();
        bus.in_valid = 0;
        check("t5_level", bus.water_level, 100);
        check("t5_no_bubble", bus.out_valid, 1);
        check("t5_next_idx0", bus.out_data, pat(1, 0));
        drain(1500);

        // Reset in the middle of a word
        do_reset();
        bus.out_ready = 1;
        bus.in_valid = 1;
        for (int w = 0; w < 5; w++) begin
            bus.in_data = mk(w);
            step();
        end
        bus.in_valid = 0;
        for (int n = 0; n < 100 && consumed < 28; n++) step();
        check("t6_mid_word", bus.out_data, pat(3, 4));
        do_reset();
        bus.out_ready = 1;
        bus.in_valid = 1;
        bus.in_data = mk(77);
        step();
        bus.in_valid = 0;
        step();
        check("t6_fresh", bus.out_data, pat(77, 0));
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
